// File: rtl/credit_wallet_if.sv
// credit_wallet_if
// Groups the keyboard, game-start and display signals of the credit wallet.
//   i_keydown      a key is currently held (keyboard decoder)
//   i_ready        keyboard decoder output valid
//   i_last_change  code of the most recent key
//   i_ticket       level-held ticket flag from the game-start screen
//   i_win          game-over-with-win flag (level or pulse)
//   i_prize        credit to add on a win edge
//   o_money        current balance
//   o_tens/o_ones  BCD digits of the balance (one cycle behind o_money)
//   o_denied       one-cycle pulse: ticket edge with insufficient balance
//   o_full         balance is at the ceiling
//   o_coin_busy    coin cooldown running
// master drives the inputs (keyboard/game side); slave is the wallet.
interface credit_wallet_if;
   logic       i_keydown;
   logic       i_ready;
   logic [8:0] i_last_change;
   logic       i_ticket;
   logic       i_win;
   logic [6:0] i_prize;
   logic [6:0] o_money;
   logic [3:0] o_tens;
   logic [3:0] o_ones;
   logic       o_denied;
   logic       o_full;
   logic       o_coin_busy;

   modport master (
      output i_keydown, i_ready, i_last_change, i_ticket, i_win, i_prize,
      input  o_money, o_tens, o_ones, o_denied, o_full, o_coin_busy
   );

   modport slave (
      input  i_keydown, i_ready, i_last_change, i_ticket, i_win, i_prize,
      output o_money, o_tens, o_ones, o_denied, o_full, o_coin_busy
   );
endinterface

// File: rtl/credit_wallet.sv
// credit_wallet
// Coin-credit store for the arcade flow. Adds credit on a coin key press and
// on a win edge, deducts the entry cost on each rising edge of the ticket,
// and presents the balance as BCD digits for the seven-segment display.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  credit_wallet_if.slave (keyboard, ticket, win/prize, balance outputs)
module credit_wallet #(
   parameter logic [8:0] KEY_COIN    = 9'b0_0010_0001,
   parameter int         COIN_VALUE  = 5,
   parameter int         TICKET_COST = 10,
   parameter int         MAX_MONEY   = 99,
   parameter int         INIT_MONEY  = 0,
   parameter int         COOLDOWN    = 25_000_000,
   parameter int         CD_W        = 25
) (
   input logic            clk,
   input logic            rst,
   credit_wallet_if.slave bus
);

   localparam logic [7:0]      LP_COIN      = 8'(COIN_VALUE);
   localparam logic [7:0]      LP_COST      = 8'(TICKET_COST);
   localparam logic [7:0]      LP_MAX       = 8'(MAX_MONEY);
   localparam logic [6:0]      LP_INIT      = 7'(INIT_MONEY);
   localparam logic [3:0]      LP_INIT_TENS = 4'(INIT_MONEY / 10);
   localparam logic [3:0]      LP_INIT_ONES = 4'(INIT_MONEY % 10);
   localparam logic [CD_W-1:0] LP_CD_LOAD   = CD_W'(COOLDOWN - 1);
   localparam logic [CD_W-1:0] LP_CD_ONE    = CD_W'(1);

   logic [6:0]      r_money;
   logic [3:0]      r_tens;
   logic [3:0]      r_ones;
   logic            r_denied;
   logic [CD_W-1:0] r_cd;
   logic            r_kv_q;
   logic            r_tk_q;
   logic            r_win_q;

   logic            w_kv;
   logic            w_coin_busy;
   logic            w_coin_evt;
   logic            w_tick_evt;
   logic            w_win_evt;
   logic            w_afford;
   logic [7:0]      w_sum;
   logic [6:0]      w_money_next;
   logic [CD_W-1:0] w_cd_next;
   logic [11:0]     w_ge;
   logic [3:0]      w_tens;
   logic [3:0]      w_ones;

   // Edge detection on the keyboard strobe, ticket and win flags.
   assign w_kv        = bus.i_keydown & bus.i_ready;
   assign w_coin_busy = (r_cd != '0);
   assign w_coin_evt  = w_kv & ~r_kv_q & (bus.i_last_change == KEY_COIN) & ~w_coin_busy;
   assign w_tick_evt  = bus.i_ticket & ~r_tk_q;
   assign w_win_evt   = bus.i_win & ~r_win_q;
   // Affordability is judged on the balance before this cycle's credits.
   assign w_afford    = ({1'b0, r_money} >= LP_COST);

   // 8-bit sum cannot wrap: worst case 99+5+127, and the cost is only
   // subtracted when the pre-update balance already covers it.
   always_comb begin
      w_sum = {1'b0, r_money};
      if (w_coin_evt) w_sum = w_sum + LP_COIN;
      if (w_win_evt)  w_sum = w_sum + {1'b0, bus.i_prize};
      if (w_tick_evt && w_afford) w_sum = w_sum - LP_COST;
      w_money_next = (w_sum > LP_MAX) ? LP_MAX[6:0] : w_sum[6:0];
   end

   // Cooldown: load on an accepted coin, count down to zero and hold.
   always_comb begin
      w_cd_next = r_cd;
      if (w_coin_evt)       w_cd_next = LP_CD_LOAD;
      else if (w_coin_busy) w_cd_next = r_cd - LP_CD_ONE;
   end

   // Divide-by-10 for values up to 127: tens is the number of multiples of
   // ten not exceeding the balance; ones is the remainder.
   genvar gi;
   generate
      for (gi = 1; gi <= 12; gi++) begin : g_ge
         assign w_ge[gi-1] = (r_money >= 7'(10 * gi));
      end
   endgenerate

   always_comb begin
      w_tens = '0;
      for (int k = 0; k < 12; k++) w_tens = w_tens + 4'(w_ge[k]);
      w_ones = 4'(r_money - 7'(w_tens) * 7'd10);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_money  <= LP_INIT;
         r_tens   <= LP_INIT_TENS;
         r_ones   <= LP_INIT_ONES;
         r_denied <= 1'b0;
         r_cd     <= '0;
         r_kv_q   <= 1'b0;
         r_tk_q   <= 1'b0;
         r_win_q  <= 1'b0;
      end else begin
         r_money  <= w_money_next;
         r_tens   <= w_tens;
         r_ones   <= w_ones;
         r_denied <= w_tick_evt & ~w_afford;
         r_cd     <= w_cd_next;
         r_kv_q   <= w_kv;
         r_tk_q   <= bus.i_ticket;
         r_win_q  <= bus.i_win;
      end
   end

   assign bus.o_money     = r_money;
   assign bus.o_tens      = r_tens;
   assign bus.o_ones      = r_ones;
   assign bus.o_denied    = r_denied;
   assign bus.o_full      = ({1'b0, r_money} == LP_MAX);
   assign bus.o_coin_busy = w_coin_busy;

endmodule

// File: tb/tb_credit_wallet.sv
// tb_credit_wallet
// Directed stimulus for credit_wallet with a scoreboard: each stimulus step
// pushes the balance event it should cause; a monitor pops an entry whenever
// the balance changes or denied pulses, and checks the BCD digits one cycle
// later. Events with nothing queued are reported as unexpected.
module tb_credit_wallet;

   localparam logic [8:0] KEY = 9'b0_0010_0001;

   typedef struct {
      logic [6:0] money;
      logic       den;
      logic       full;
      logic [3:0] tens;
      logic [3:0] ones;
   } exp_t;

   logic clk;
   logic rst;
   credit_wallet_if bus();

   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;
   logic mon_en;

   credit_wallet #(
      .COOLDOWN (20),
      .CD_W     (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int m, input int d, input int f, input int t, input int o);
      exp_t e;
      e.money = 7'(m);
      e.den   = 1'(d);
      e.full  = 1'(f);
      e.tens  = 4'(t);
      e.ones  = 4'(o);
      exp_q.push_back(e);
   endtask

   task automatic coin(input int hold);
      @(negedge clk);
      bus.i_keydown     = 1'b1;
      bus.i_ready       = 1'b1;
      bus.i_last_change = KEY;
      repeat (hold) @(negedge clk);
      bus.i_keydown = 1'b0;
      bus.i_ready   = 1'b0;
   endtask

   task automatic win_pulse(input int p);
      @(negedge clk);
      bus.i_win   = 1'b1;
      bus.i_prize = 7'(p);
      @(negedge clk);
      bus.i_win = 1'b0;
   endtask

   // Monitor / scoreboard
   initial begin
      logic [6:0] prev_money;
      logic       bcd_pend;
      logic [3:0] pend_t;
      logic [3:0] pend_o;
      exp_t       e;
      prev_money = 7'd0;
      bcd_pend   = 1'b0;
      pend_t     = 4'd0;
      pend_o     = 4'd0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (bcd_pend) begin
            check("tens", bus.o_tens, pend_t);
            check("ones", bus.o_ones, pend_o);
            bcd_pend = 1'b0;
         end
         if (bus.o_money !== prev_money || bus.o_denied === 1'b1) begin
            $display("event: money=%0d denied=%0b full=%0b", bus.o_money, bus.o_denied, bus.o_full);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: got money=%0d denied=%0b, required no event",
                        bus.o_money, bus.o_denied);
            end else begin
               e = exp_q.pop_front();
               check("money", bus.o_money, e.money);
               check("denied", bus.o_denied, e.den);
               check("full", bus.o_full, e.full);
               pend_t   = e.tens;
               pend_o   = e.ones;
               bcd_pend = 1'b1;
            end
         end
         prev_money = bus.o_money;
      end
   end

   // Stimulus
   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      mon_en = 1'b0;
      rst    = 1'b1;
      bus.i_keydown     = 1'b0;
      bus.i_ready       = 1'b0;
      bus.i_last_change = 9'd0;
      bus.i_ticket      = 1'b0;
      bus.i_win         = 1'b0;
      bus.i_prize       = 7'd0;

      repeat (3) @(negedge clk);
      check("rst_money", bus.o_money, 0);
      check("rst_tens", bus.o_tens, 0);
      check("rst_ones", bus.o_ones, 0);
      check("rst_denied", bus.o_denied, 0);
      check("rst_full", bus.o_full, 0);
      check("rst_busy", bus.o_coin_busy, 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Coin held 50 cycles: inserts once, cooldown runs then clears
      push(5, 0, 0, 0, 5);
      @(negedge clk);
      bus.i_keydown     = 1'b1;
      bus.i_ready       = 1'b1;
      bus.i_last_change = KEY;
      @(negedge clk);
      check("busy_after_coin", bus.o_coin_busy, 1);
      repeat (49) @(negedge clk);
      bus.i_keydown = 1'b0;
      bus.i_ready   = 1'b0;
      check("busy_expired", bus.o_coin_busy, 0);
      repeat (5) @(negedge clk);

      // Second coin accepted, third press within cooldown dropped
      push(10, 0, 0, 1, 0);
      coin(3);
      repeat (2) @(negedge clk);
      coin(3);
      check("busy_during_drop", bus.o_coin_busy, 1);
      repeat (30) @(negedge clk);

      // Ticket held 100 cycles at 10: one deduction, no denial
      push(0, 0, 0, 0, 0);
      @(negedge clk);
      bus.i_ticket = 1'b1;
      repeat (100) @(negedge clk);
      bus.i_ticket = 1'b0;
      repeat (3) @(negedge clk);

      // Back to 5, then a ticket edge is denied
      push(5, 0, 0, 0, 5);
      coin(3);
      repeat (25) @(negedge clk);
      push(5, 1, 0, 0, 5);
      @(negedge clk);
      bus.i_ticket = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_ticket = 1'b0;
      repeat (3) @(negedge clk);

      // Win to 97, coin saturates at 99, further win stays at 99
      push(97, 0, 0, 9, 7);
      win_pulse(92);
      repeat (3) @(negedge clk);
      push(99, 0, 1, 9, 9);
      coin(3);
      win_pulse(20);
      repeat (2) @(negedge clk);
      check("sat_money", bus.o_money, 99);
      check("sat_full", bus.o_full, 1);
      check("busy_before_rst", bus.o_coin_busy, 1);

      // Reset mid-cooldown returns everything immediately
      push(0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("busy_in_rst", bus.o_coin_busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // To 10, then coin + win(3) + ticket in the same cycle: 10+5+3-10
      push(10, 0, 0, 1, 0);
      win_pulse(10);
      repeat (3) @(negedge clk);
      push(8, 0, 0, 0, 8);
      @(negedge clk);
      bus.i_keydown     = 1'b1;
      bus.i_ready       = 1'b1;
      bus.i_last_change = KEY;
      bus.i_ticket      = 1'b1;
      bus.i_win         = 1'b1;
      bus.i_prize       = 7'd3;
      @(negedge clk);
      bus.i_keydown = 1'b0;
      bus.i_ready   = 1'b0;
      bus.i_ticket  = 1'b0;
      bus.i_win     = 1'b0;
      repeat (5) @(negedge clk);

      check("events_outstanding", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
